ddr2_phy_pll_phase_step_ctrl: RTL
=================================

Name: ddr2_phy_pll_phase_step_ctrl

Overview:
- PLL dynamic phase-shift controller directly downstream of the PHY sequencer.
- Converts the sequencer's single-cycle reconfigure request (start, clock index, direction) into a PLL phase-step handshake: phasecounterselect, phaseupdown, phasestep, phasedone.
- Reports `phs_shft_busy` back to the sequencer.
- Tracks the current resync-clock phase position and flags handshake timeouts and dropped requests.

Parameters:
- CLOCK_INDEX_WIDTH, 4, width of clock index / PLL phasecounterselect.
- PLL_STEPS_PER_CYCLE, 32, phase steps per clock period; position wraps modulo this.
- PHASE_POS_WIDTH, 5, width of resync_phase_pos; must be ≥ clog2(PLL_STEPS_PER_CYCLE).
- SETUP_CYCLES, 2, cycles select/updown are held stable before phasestep rises.
- STEP_CYCLES, 2, cycles phasestep is held high (minimum 1).
- RECOVER_CYCLES, 4, guard cycles after phasedone before accepting the next request.
- TIMEOUT_CYCLES, 1024, maximum cycles waiting for any phasedone edge.
- SYNC_STAGES, 2, synchroniser depth for pll_phasedone and pll_locked.

Ports:
- seq_clk  in  1  sequencer clock.
- reset_seq_n  in  1  reset, asynchronous, active-low.
- seq_pll_start_reconfig  in  1  one-cycle request pulse from sequencer.
- seq_pll_select  in  CLOCK_INDEX_WIDTH  PLL counter to step, valid with request.
- seq_pll_inc_dec_n  in  1  1 = increment phase, 0 = decrement, valid with request.
- resync_clk_index  in  CLOCK_INDEX_WIDTH  index of resync clock, static after reset.
- pll_locked  in  1  PLL lock, asynchronous.
- pll_phasedone  in  1  PLL phase-done, asynchronous, active-high, drops low while a step is in progress.
- pll_phasecounterselect  out  CLOCK_INDEX_WIDTH  to PLL.
- pll_phaseupdown  out  1  to PLL.
- pll_phasestep  out  1  to PLL.
- phs_shft_busy  out  1  to sequencer.
- resync_phase_pos  out  PHASE_POS_WIDTH  current resync clock phase step.
- step_timeout_err  out  1  sticky; a handshake timed out.
- dropped_req_err  out  1  sticky; a request arrived while busy.

Behaviour:
- Reset values:
  - phs_shft_busy = 1.
  - pll_phasestep = 0, pll_phaseupdown = 0, pll_phasecounterselect = 0.
  - resync_phase_pos = 0.
  - Both error flags = 0.
  - FSM state = LOCK_WAIT.
  - Synchroniser flops = 0.
- All outputs are registered. pll_phasedone and pll_locked pass through SYNC_STAGES flops; "done_s" and "locked_s" below denote the synchronised values.
- FSM states and transitions:
  - LOCK_WAIT: busy = 1. When locked_s = 1, go to IDLE.
  - IDLE: busy = 0.
    - If locked_s = 0, go to LOCK_WAIT.
    - Else on start = 1: latch select to pll_phasecounterselect and inc_dec_n to pll_phaseupdown; set busy = 1 on the next edge (busy high 1 cycle after the request); go to SETUP.
  - SETUP: hold for SETUP_CYCLES, then set phasestep = 1 and go to STEP.
  - STEP: hold phasestep for STEP_CYCLES, then clear phasestep and go to WAIT_LOW.
  - WAIT_LOW: wait for done_s = 0, then go to WAIT_HIGH.
  - WAIT_HIGH: wait for done_s = 1, then:
    - If latched select == resync_clk_index, update resync_phase_pos: +1 if phaseupdown = 1, else −1.
    - Go to RECOVER.
  - RECOVER: hold for RECOVER_CYCLES, then go to IDLE. busy falls on the edge entering IDLE.
- Wrap rules for resync_phase_pos:
  - PLL_STEPS_PER_CYCLE−1, incremented, becomes 0.
  - 0, decremented, becomes PLL_STEPS_PER_CYCLE−1.
- Timeout:
  - A single counter clears on entry to WAIT_LOW and counts through WAIT_LOW and WAIT_HIGH.
  - On reaching TIMEOUT_CYCLES: set step_timeout_err, leave resync_phase_pos unchanged, go to RECOVER.
- Requests:
  - start in any state other than IDLE sets dropped_req_err; the request is otherwise ignored.
  - A request in the same cycle as the RECOVER→IDLE edge is also dropped.
- Loss of lock: locked_s = 0 in any non-IDLE state:
  - Clear phasestep and abort to LOCK_WAIT; busy stays 1.
  - resync_phase_pos is unchanged unless the WAIT_HIGH completion occurs in that same cycle, in which case completion wins.
- Asynchronous reset mid-handshake forces all reset values immediately, including phasestep = 0.

Decomposition:
- Shared package ddr2_phy_seq_pkg holds:
  - FSM state enum (LOCK_WAIT, IDLE, SETUP, STEP, WAIT_LOW, WAIT_HIGH, RECOVER).
  - CLOCK_INDEX_WIDTH and PLL_STEPS_PER_CYCLE defaults.
- One sub-module: ddr2_phy_sync_bit, a SYNC_STAGES flop synchroniser with parameterised reset value, instantiated twice.

Test Plan:
- Reset release with pll_locked = 0 for 50 cycles, then 1 → busy = 1 throughout; busy = 0 exactly SYNC_STAGES+1 cycles after locked rises.
- Request select = resync_clk_index = 3, inc = 1, PLL model drops phasedone for 5 cycles → phasestep high 2 cycles after 2 setup cycles; resync_phase_pos 0→1; busy high for the whole handshake plus 4 recover cycles.
- Request select = 3, inc = 0 with pos = 0 → pos = 31 (wrap). Request select = 2 → pos unchanged, counter 2 stepped.
- PLL model never toggles phasedone → step_timeout_err = 1 after 1024 wait cycles; FSM returns to IDLE; pos unchanged; next request is serviced normally.
- Second start pulse while in STEP → dropped_req_err = 1; only one phasestep pulse observed.
- pll_locked drops during WAIT_LOW → phasestep = 0, busy stays 1, state LOCK_WAIT. Async reset mid-STEP → phasestep = 0 and busy = 1 in the same cycle.

Source files
------------

// File: rtl/ddr2_phy_seq_pkg.sv
// Shared sequencer-side types and defaults for the DDR2 PHY PLL phase-step path.
package ddr2_phy_seq_pkg;

    localparam int CLOCK_INDEX_WIDTH_DEF   = 4;
    localparam int PLL_STEPS_PER_CYCLE_DEF = 32;

    typedef enum logic [2:0] {
        LOCK_WAIT,
        IDLE,
        SETUP,
        STEP,
        WAIT_LOW,
        WAIT_HIGH,
        RECOVER
    } phs_state_t;

    // One phase step on a ring of 'steps' positions.
    function automatic int unsigned phase_step(int unsigned pos, logic up, int unsigned steps);
        if (up)
            return (pos == steps - 1) ? 0 : pos + 1;
        return (pos == 0) ? steps - 1 : pos - 1;
    endfunction

endpackage

// File: rtl/ddr2_phy_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous control bit.
module ddr2_phy_sync_bit #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic seq_clk,
    input  logic reset_seq_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge seq_clk or negedge reset_seq_n) begin
        if (!reset_seq_n) begin
            ff <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            ff[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++)
                ff[i] <= ff[i-1];
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/ddr2_phy_pll_phase_step_ctrl.sv
// Turns a sequencer phase-shift request into the PLL phasestep/phasedone handshake
// and tracks the resync clock's phase position.
module ddr2_phy_pll_phase_step_ctrl
    import ddr2_phy_seq_pkg::*;
#(
    parameter int CLOCK_INDEX_WIDTH   = CLOCK_INDEX_WIDTH_DEF,
    parameter int PLL_STEPS_PER_CYCLE = PLL_STEPS_PER_CYCLE_DEF,
    parameter int PHASE_POS_WIDTH     = 5,
    parameter int SETUP_CYCLES        = 2,
    parameter int STEP_CYCLES         = 2,
    parameter int RECOVER_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES      = 1024,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                         seq_clk,
    input  logic                         reset_seq_n,
    input  logic                         seq_pll_start_reconfig,
    input  logic [CLOCK_INDEX_WIDTH-1:0] seq_pll_select,
    input  logic                         seq_pll_inc_dec_n,
    input  logic [CLOCK_INDEX_WIDTH-1:0] resync_clk_index,
    input  logic                         pll_locked,
    input  logic                         pll_phasedone,
    output logic [CLOCK_INDEX_WIDTH-1:0] pll_phasecounterselect,
    output logic                         pll_phaseupdown,
    output logic                         pll_phasestep,
    output logic                         phs_shft_busy,
    output logic [PHASE_POS_WIDTH-1:0]   resync_phase_pos,
    output logic                         step_timeout_err,
    output logic                         dropped_req_err
);

    localparam int CNT_MAX = (SETUP_CYCLES > STEP_CYCLES)
                           ? ((SETUP_CYCLES > RECOVER_CYCLES) ? SETUP_CYCLES : RECOVER_CYCLES)
                           : ((STEP_CYCLES > RECOVER_CYCLES) ? STEP_CYCLES : RECOVER_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          done_s;
    logic          locked_s;
    phs_state_t    state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;

    ddr2_phy_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_done (
        .seq_clk     (seq_clk),
        .reset_seq_n (reset_seq_n),
        .d           (pll_phasedone),
        .q           (done_s)
    );

    ddr2_phy_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_locked (
        .seq_clk     (seq_clk),
        .reset_seq_n (reset_seq_n),
        .d           (pll_locked),
        .q           (locked_s)
    );

    always_ff @(posedge seq_clk or negedge reset_seq_n) begin
        if (!reset_seq_n) begin
            state                  <= LOCK_WAIT;
            cnt                    <= '0;
            tcnt                   <= '0;
            phs_shft_busy          <= 1'b1;
            pll_phasestep          <= 1'b0;
            pll_phaseupdown        <= 1'b0;
            pll_phasecounterselect <= '0;
            resync_phase_pos       <= '0;
            step_timeout_err       <= 1'b0;
            dropped_req_err        <= 1'b0;
        end else begin
            // Only IDLE can take a request, so the RECOVER->IDLE edge drops one too.
            if (seq_pll_start_reconfig && state != IDLE)
                dropped_req_err <= 1'b1;

            case (state)
                LOCK_WAIT: begin
                    if (locked_s) begin
                        state         <= IDLE;
                        phs_shft_busy <= 1'b0;
                    end
                end
                IDLE: begin
                    if (!locked_s) begin
                        state         <= LOCK_WAIT;
                        phs_shft_busy <= 1'b1;
                    end else if (seq_pll_start_reconfig) begin
                        pll_phasecounterselect <= seq_pll_select;
                        pll_phaseupdown        <= seq_pll_inc_dec_n;
                        phs_shft_busy          <= 1'b1;
                        cnt                    <= '0;
                        state                  <= SETUP;
                    end
                end
                default: begin
                    // A completing handshake still counts even if lock drops the same cycle.
                    if (state == WAIT_HIGH && done_s && pll_phasecounterselect == resync_clk_index)
                        resync_phase_pos <= PHASE_POS_WIDTH'(phase_step(32'(resync_phase_pos),
                                                pll_phaseupdown, PLL_STEPS_PER_CYCLE));

                    if (!locked_s) begin
                        pll_phasestep <= 1'b0;
                        state         <= LOCK_WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                        case (state)
                            SETUP: begin
                                if (cnt == CW'(SETUP_CYCLES - 1)) begin
                                    pll_phasestep <= 1'b1;
                                    cnt           <= '0;
                                    state         <= STEP;
                                end
                            end
                            STEP: begin
                                if (cnt == CW'(STEP_CYCLES - 1)) begin
                                    pll_phasestep <= 1'b0;
                                    tcnt          <= '0;
                                    state         <= WAIT_LOW;
                                end
                            end
                            WAIT_LOW: begin
                                tcnt <= tcnt + TW'(1);
                                if (!done_s) begin
                                    state <= WAIT_HIGH;
                                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                                    step_timeout_err <= 1'b1;
                                    cnt              <= '0;
                                    state            <= RECOVER;
                                end
                            end
                            WAIT_HIGH: begin
                                tcnt <= tcnt + TW'(1);
                                if (done_s) begin
                                    cnt   <= '0;
                                    state <= RECOVER;
                                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                                    step_timeout_err <= 1'b1;
                                    cnt              <= '0;
                                    state            <= RECOVER;
                                end
                            end
                            RECOVER: begin
                                if (cnt == CW'(RECOVER_CYCLES - 1)) begin
                                    state         <= IDLE;
                                    phs_shft_busy <= 1'b0;
                                end
                            end
                            default: state <= LOCK_WAIT;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
